// File: rtl/timer_sequencer.sv
// Queues interval lengths from a valid/ready stream and feeds them to a countdown timer one at a time.
// Tracks completed intervals with a wrapping count and supports a synchronous flush of queued work.
module timer_sequencer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_cycles,
    input  logic                     abort,
    input  logic                     timer_busy,
    output logic                     timer_load,
    output logic [WIDTH-1:0]         timer_cycles,
    output logic                     done,
    output logic [7:0]               done_count,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     zero_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             accept;
    logic             push;
    logic             pop;

    // in_ready depends only on registered occupancy, never on the pop side.
    assign in_ready = (count != FULL_COUNT);
    assign pending  = count;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !abort && (in_cycles != '0);
    assign pop      = (state == IDLE) && (count != '0) && !timer_busy && !abort;

    // NOTE: storage carries no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_cycles;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            timer_load   <= 1'b0;
            timer_cycles <= '0;
            done         <= 1'b0;
            done_count   <= '0;
            zero_drop    <= 1'b0;
        end else begin
            timer_load <= 1'b0;
            done       <= 1'b0;
            zero_drop  <= accept && !abort && (in_cycles == '0);

            if (abort) begin
                // Flush queued work; a running timer is left alone and IDLE waits for it.
                state  <= IDLE;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (pop) begin
                            timer_load   <= 1'b1;
                            timer_cycles <= mem[rd_ptr];
                            state        <= LOAD;
                        end
                    end
                    LOAD: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (!timer_busy) begin
                            done       <= 1'b1;
                            done_count <= done_count + 1'b1;
                            state      <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
